mem_stage: RTL and testbench

- MIPS MEM stage. Consumes the EX/MEM latch outputs of the execute stage and resolves branch select.
- Performs data-memory load/store against an internal word-addressed RAM.
- Registers results into the MEM/WB latch that feeds writeback.
- Sits between execute and writeback.

---
 rtl/mips_mem_pkg.sv | 11 +
 rtl/mem_stage_data_memory.sv | 25 ++
 rtl/mem_stage.sv | 99 +++++++++
 tb/tb_mem_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: control-bit positions and widths shared by the MEM stage and its bench.
// No logic or state; constants only.
// Carries no flow control.
package mips_mem_pkg;
    localparam int CTLWB_REGWRITE = 1;
    localparam int CTLWB_MEMTOREG = 0;
    localparam int CTLM_MEMREAD   = 1;
    localparam int CTLM_MEMWRITE  = 0;
    localparam int DATA_W         = 32;
    localparam int REG_W          = 5;
endpackage

// File: rtl/mem_stage_data_memory.sv
// data_memory: single-port word RAM, read-before-write, contents never reset.
// Latency: rdata valid one clock after addr is presented.
// No backpressure: one access per clock; the caller gates we.
import mips_mem_pkg::*;

module data_memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Reading the array before the write takes effect gives the old word on a same-cycle hit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage - branch select, data-memory access, MEM/WB latch (MEM_ALIGN_CHECK_EN adds misalign_err).
// Latency: pcsrc/branch_target combinational; load data and latch outputs one clock.
// Backpressure: stall holds the MEM/WB latch and blocks stores; rst overrides stall.
import mips_mem_pkg::*;

module mem_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  ctlwb_in,
    input  logic [1:0]  ctlm_in,
    input  logic        branch_in,
    input  logic        zero_in,
    input  logic [31:0] adder_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rdata2_in,
    input  logic [4:0]  muxout_in,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic [1:0]  ctlwb_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  muxout_out
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);
    logic [ADDR_W-1:0] index;
    logic              memread;
    logic              memwrite;
    logic              misaligned;
    logic              load_en;
    logic              we;
    logic [31:0]       ram_rdata;
    logic [31:0]       hold_q;
    logic              use_ram_q;
    logic              unused_addr_bits;

    assign index            = alu_result_in[ADDR_W+1:2];
    assign unused_addr_bits = ^{alu_result_in[31:ADDR_W+2], alu_result_in[1:0]};
    assign memread          = ctlm_in[CTLM_MEMREAD];
    assign memwrite         = ctlm_in[CTLM_MEMWRITE];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (memread | memwrite) & (alu_result_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign load_en = memread & ~misaligned;
    assign we      = memwrite & ~misaligned & ~stall & ~rst;

    assign pcsrc         = branch_in & zero_in;
    assign branch_target = adder_in;

    data_memory #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk   (clk),
        .we    (we),
        .addr  (index),
        .wdata (rdata2_in),
        .rdata (ram_rdata)
    );

    // The RAM output register keeps tracking addr during a stall, so the visible
    // load word is parked in hold_q and the RAM path is deselected until the next advance.
    assign read_data_out = use_ram_q ? ram_rdata : hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctlwb_out      <= '0;
            alu_result_out <= '0;
            muxout_out     <= '0;
            hold_q         <= '0;
            use_ram_q      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_err   <= 1'b0;
`endif
        end else if (!stall) begin
            ctlwb_out      <= ctlwb_in;
            alu_result_out <= alu_result_in;
            muxout_out     <= muxout_in;
            hold_q         <= '0;
            use_ram_q      <= load_en;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_err   <= misaligned;
`endif
        end else begin
            hold_q         <= read_data_out;
            use_ram_q      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table driving mem_stage one clock per row, plus branch-path sequences.
// Outputs are sampled 1 time unit after the rising edge.
import mips_mem_pkg::*;

module tb_mem_stage;
    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  ctlwb_in;
    logic [1:0]  ctlm_in;
    logic        branch_in;
    logic        zero_in;
    logic [31:0] adder_in;
    logic [31:0] alu_result_in;
    logic [31:0] rdata2_in;
    logic [4:0]  muxout_in;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic [1:0]  ctlwb_out;
    logic [31:0] read_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  muxout_out;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int nchecks = 0;
    int nerrors = 0;

    mem_stage #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .ctlwb_in       (ctlwb_in),
        .ctlm_in        (ctlm_in),
        .branch_in      (branch_in),
        .zero_in        (zero_in),
        .adder_in       (adder_in),
        .alu_result_in  (alu_result_in),
        .rdata2_in      (rdata2_in),
        .muxout_in      (muxout_in),
        .pcsrc          (pcsrc),
        .branch_target  (branch_target),
        .ctlwb_out      (ctlwb_out),
        .read_data_out  (read_data_out),
        .alu_result_out (alu_result_out),
        .muxout_out     (muxout_out)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  ctlwb;
        logic [1:0]  ctlm;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  mux;
        logic [1:0]  e_wb;
        logic [31:0] e_rd;
        logic [31:0] e_alu;
        logic [4:0]  e_mux;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic [1:0] wb,
                                input logic [1:0] m, input logic [31:0] a, input logic [31:0] d,
                                input logic [4:0] x, input logic [1:0] ewb, input logic [31:0] erd,
                                input logic [31:0] ealu, input logic [4:0] emux, input logic emis);
        vec_t v;
        v.rst = r;   v.stall = s; v.ctlwb = wb; v.ctlm = m; v.alu = a; v.wd = d; v.mux = x;
        v.e_wb = ewb; v.e_rd = erd; v.e_alu = ealu; v.e_mux = emux; v.e_mis = emis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] misaligned_load_rd;

    initial begin
`ifdef MEM_ALIGN_CHECK_EN
        misaligned_load_rd = 32'h0;
`else
        misaligned_load_rd = 32'd9;
`endif
        //               rst  stall wb     ctlm   alu            wdata          mux    e_wb   e_rd            e_alu          e_mux  e_mis
        vecs.push_back(mk(1, 0, 2'b11, 2'b11, 32'hFFFF_FFFF, 32'h1111_1111, 5'd31, 2'b00, 32'h0,          32'h0,         5'd0,  0)); // 0 reset
        vecs.push_back(mk(1, 0, 2'b11, 2'b11, 32'hFFFF_FFFF, 32'h1111_1111, 5'd31, 2'b00, 32'h0,          32'h0,         5'd0,  0)); // 1 reset
        vecs.push_back(mk(0, 0, 2'b00, 2'b01, 32'd40,        32'hDEAD_BEEF, 5'd0,  2'b00, 32'h0,          32'd40,        5'd0,  0)); // 2 store
        vecs.push_back(mk(0, 0, 2'b11, 2'b10, 32'd40,        32'h0,         5'd7,  2'b11, 32'hDEAD_BEEF,  32'd40,        5'd7,  0)); // 3 load
        vecs.push_back(mk(0, 0, 2'b00, 2'b01, 32'd40,        32'd5,         5'd0,  2'b00, 32'h0,          32'd40,        5'd0,  0)); // 4 mem[10]=5
        vecs.push_back(mk(0, 0, 2'b11, 2'b11, 32'd40,        32'd9,         5'd3,  2'b11, 32'd5,          32'd40,        5'd3,  0)); // 5 rd+wr
        vecs.push_back(mk(0, 0, 2'b11, 2'b10, 32'd40,        32'h0,         5'd3,  2'b11, 32'd9,          32'd40,        5'd3,  0)); // 6 new word
        vecs.push_back(mk(0, 0, 2'b10, 2'b00, 32'd1064,      32'h0,         5'd10, 2'b10, 32'h0,          32'd1064,      5'd10, 0)); // 7 passthru
        vecs.push_back(mk(0, 0, 2'b11, 2'b10, 32'd1064,      32'h0,         5'd2,  2'b11, 32'd9,          32'd1064,      5'd2,  0)); // 8 alias
        vecs.push_back(mk(0, 0, 2'b00, 2'b01, 32'd12,        32'h33,        5'd0,  2'b00, 32'h0,          32'd12,        5'd0,  0)); // 9 mem[3]
        vecs.push_back(mk(0, 0, 2'b11, 2'b10, 32'd12,        32'h0,         5'd4,  2'b11, 32'h33,         32'd12,        5'd4,  0)); // 10 load
        vecs.push_back(mk(0, 1, 2'b00, 2'b01, 32'd12,        32'hBAD,       5'd31, 2'b11, 32'h33,         32'd12,        5'd4,  0)); // 11 stall
        vecs.push_back(mk(0, 1, 2'b00, 2'b11, 32'd40,        32'hBAD,       5'd31, 2'b11, 32'h33,         32'd12,        5'd4,  0)); // 12 stall
        vecs.push_back(mk(0, 1, 2'b00, 2'b01, 32'd12,        32'hBAD,       5'd31, 2'b11, 32'h33,         32'd12,        5'd4,  0)); // 13 stall
        vecs.push_back(mk(0, 0, 2'b01, 2'b10, 32'd12,        32'h0,         5'd5,  2'b01, 32'h33,         32'd12,        5'd5,  0)); // 14 no write
        vecs.push_back(mk(0, 0, 2'b01, 2'b10, 32'd40,        32'h0,         5'd6,  2'b01, 32'd9,          32'd40,        5'd6,  0)); // 15 no write
        vecs.push_back(mk(0, 1, 2'b00, 2'b00, 32'd0,         32'h0,         5'd0,  2'b01, 32'd9,          32'd40,        5'd6,  0)); // 16 stall
        vecs.push_back(mk(1, 1, 2'b11, 2'b10, 32'd40,        32'h0,         5'd9,  2'b00, 32'h0,          32'h0,         5'd0,  0)); // 17 rst>stall
        vecs.push_back(mk(0, 0, 2'b11, 2'b10, 32'd41,        32'h0,         5'd8,  2'b11, misaligned_load_rd, 32'd41,    5'd8,  1)); // 18 low bits
        vecs.push_back(mk(1, 0, 2'b00, 2'b01, 32'd40,        32'h77,        5'd0,  2'b00, 32'h0,          32'h0,         5'd0,  0)); // 19 rst drops st
        vecs.push_back(mk(0, 0, 2'b10, 2'b10, 32'd40,        32'h0,         5'd1,  2'b10, 32'd9,          32'd40,        5'd1,  0)); // 20 load

        branch_in = 1'b0;
        zero_in   = 1'b0;
        adder_in  = 32'h0;

        for (int i = 0; i < vecs.size(); i++) begin
            rst           = vecs[i].rst;
            stall         = vecs[i].stall;
            ctlwb_in      = vecs[i].ctlwb;
            ctlm_in       = vecs[i].ctlm;
            alu_result_in = vecs[i].alu;
            rdata2_in     = vecs[i].wd;
            muxout_in     = vecs[i].mux;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ctlwb_out", i),      {30'h0, ctlwb_out}, {30'h0, vecs[i].e_wb});
            chk($sformatf("v%0d read_data_out", i),  read_data_out,      vecs[i].e_rd);
            chk($sformatf("v%0d alu_result_out", i), alu_result_out,     vecs[i].e_alu);
            chk($sformatf("v%0d muxout_out", i),     {27'h0, muxout_out}, {27'h0, vecs[i].e_mux});
`ifdef MEM_ALIGN_CHECK_EN
            chk($sformatf("v%0d misalign_err", i),   {31'h0, misalign_err}, {31'h0, vecs[i].e_mis});
`endif
        end

        // Branch path is combinational and blind to stall/rst.
        rst = 1'b0; stall = 1'b0; ctlm_in = 2'b00;
        branch_in = 1'b1; zero_in = 1'b1; adder_in = 32'd124;
        #1;
        chk("branch taken pcsrc", {31'h0, pcsrc}, 32'd1);
        chk("branch target", branch_target, 32'd124);
        zero_in = 1'b0;
        #1;
        chk("branch not-zero pcsrc", {31'h0, pcsrc}, 32'd0);
        branch_in = 1'b0; zero_in = 1'b1; adder_in = 32'hCAFE_0004;
        #1;
        chk("non-branch pcsrc", {31'h0, pcsrc}, 32'd0);
        chk("target passthrough", branch_target, 32'hCAFE_0004);
        rst = 1'b1; stall = 1'b1; branch_in = 1'b1; zero_in = 1'b1;
        @(posedge clk);
        #1;
        chk("pcsrc under rst+stall", {31'h0, pcsrc}, 32'd1);
        chk("target under rst+stall", branch_target, 32'hCAFE_0004);
        rst = 1'b0; stall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
